// File: rtl/snn_input_loader.sv
// Byte-stream to pixel-buffer loader feeding the SNN input layer, with registered pixel reads.
// Optional double buffering is enabled by defining SNN_LOADER_PINGPONG_EN.
module snn_input_loader #(
  parameter int DATA_W  = 8,
  parameter int PIX_W   = 1,
  parameter int NUM_PIX = 784,
  parameter int ADDR_W  = $clog2(NUM_PIX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trigger,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  output logic [PIX_W-1:0]  q,
  output logic              ready,
  output logic              frame_done
);

  localparam int PPB       = DATA_W / PIX_W;
  localparam int NUM_BYTES = (NUM_PIX * PIX_W + DATA_W - 1) / DATA_W;
  localparam int BYTE_AW   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

`ifdef SNN_LOADER_PINGPONG_EN
  localparam int NUM_BANKS = 2;
`else
  localparam int NUM_BANKS = 1;
`endif

  localparam int MEM_DEPTH = NUM_BANKS * NUM_BYTES;
  localparam int MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [BYTE_AW-1:0] LAST_BYTE = BYTE_AW'(NUM_BYTES - 1);

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [BYTE_AW-1:0] cnt_q, cnt_d;
  logic               ready_d;
  logic               frame_done_d;

  // Bank bases are flat offsets into one array; the single-bank build pins both to zero.
  int wr_base;
  int rd_base;

`ifdef SNN_LOADER_PINGPONG_EN
  logic wr_bank_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
    end else if (frame_done_d) begin
      wr_bank_q <= ~wr_bank_q;
    end
  end

  assign wr_base = wr_bank_q ? NUM_BYTES : 0;
  assign rd_base = wr_bank_q ? 0 : NUM_BYTES;
`else
  assign wr_base = 0;
  assign rd_base = 0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      cnt_q      <= '0;
      ready      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready      <= ready_d;
      frame_done <= frame_done_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;

    // A trigger in FULL finds cnt at 0, so restarting a frame is the same
    // store-and-advance as any other byte.
    if (trigger) begin
      if (cnt_q == LAST_BYTE) begin
        cnt_d        = '0;
        frame_done_d = 1'b1;
        state_d      = FULL;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        state_d = LOAD;
      end
    end

`ifdef SNN_LOADER_PINGPONG_EN
    ready_d = ready | frame_done_d;
`else
    ready_d = (state_d == FULL);
`endif
  end

  // ---------------------------------------------------------------------------
  // Byte buffer
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [MEM_AW-1:0] wr_idx;

  assign wr_idx = MEM_AW'(wr_base + int'(cnt_q));

  // NOTE: the buffer has no reset; frame contents are meaningless until a
  // frame completes, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (trigger) begin
      mem[wr_idx] <= data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: LSB-first pixel select, out-of-range addresses read as zero
  // ---------------------------------------------------------------------------
  int                rd_byte;
  int                rd_off;
  logic              rd_in_range;
  logic [MEM_AW-1:0] rd_idx;
  logic [DATA_W-1:0] rd_word;
  logic [PIX_W-1:0]  rd_pix;

  always_comb begin
    rd_in_range = (int'(addr) < NUM_PIX);
    rd_byte     = rd_in_range ? (int'(addr) / PPB) : 0;
    rd_off      = rd_in_range ? (int'(addr) % PPB) : 0;
    rd_idx      = MEM_AW'(rd_base + rd_byte);
    rd_word     = mem[rd_idx];
    rd_pix      = rd_in_range ? PIX_W'(rd_word >> (rd_off * PIX_W)) : '0;
  end

  // Sampling the array before this edge's write lands gives read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= rd_pix;
    end
  end

endmodule

// File: tb/tb_snn_input_loader.sv
// Directed self-checking bench for snn_input_loader: default 1-bit build plus a 4-bit pixel instance.
// Expectations follow SNN_LOADER_PINGPONG_EN when the bench is built with it.
module tb_snn_input_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trigger, trigger4;
  logic [7:0] data, data4;
  logic [9:0] addr, addr4;
  logic       q;
  logic [3:0] q4;
  logic       ready, frame_done, ready4, frame_done4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  snn_input_loader #(.DATA_W(8), .PIX_W(1), .NUM_PIX(784)) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .data(data), .addr(addr),
    .q(q), .ready(ready), .frame_done(frame_done)
  );

  snn_input_loader #(.DATA_W(8), .PIX_W(4), .NUM_PIX(784)) dut4 (
    .clk(clk), .rst_n(rst_n), .trigger(trigger4), .data(data4), .addr(addr4),
    .q(q4), .ready(ready4), .frame_done(frame_done4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    trigger = 1'b1;
    data    = d;
    tick();
    trigger = 1'b0;
  endtask

  task automatic send_byte4(input logic [7:0] d);
    trigger4 = 1'b1;
    data4    = d;
    tick();
    trigger4 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    trigger = 1'b0; data = '0; addr = '0;
    trigger4 = 1'b0; data4 = '0; addr4 = '0;
    #12;
    checks++; if (q !== 1'b0) begin failures++; $display("FAIL reset_q got=%b exp=0", q); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    checks++; if (q4 !== 4'h0) begin failures++; $display("FAIL reset_q4 got=%h exp=0", q4); end
    checks++; if (ready4 !== 1'b0) begin failures++; $display("FAIL reset_ready4 got=%b exp=0", ready4); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 98; i++) begin
      send_byte(8'hFF);
      if (i < 97) begin
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_early byte=%0d got=%b exp=0", i, ready); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL b2b_done_early byte=%0d got=%b exp=0", i, frame_done); end
      end else begin
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_last got=%b exp=1", ready); end
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL b2b_done_last got=%b exp=1", frame_done); end
      end
    end
    tick();
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL b2b_done_width got=%b exp=0", frame_done); end
    for (int a = 0; a < 784; a++) begin
      addr = 10'(a);
      tick();
      checks++; if (q !== 1'b1) begin failures++; $display("FAIL b2b_sweep addr=%0d got=%b exp=1", a, q); end
    end
    addr = 10'd900;
    tick();
    checks++; if (q !== 1'b0) begin failures++; $display("FAIL b2b_out_of_range addr=900 got=%b exp=0", q); end
  endtask

  task automatic test_spaced_pattern();
    logic [7:0] pat;
    int         pulses;
    pat    = 8'b1001_0011;
    pulses = 0;
    for (int i = 0; i < 98; i++) begin
      send_byte(pat);
      if (frame_done === 1'b1) pulses++;
      for (int g = 0; g < 49; g++) begin
        tick();
        if (frame_done === 1'b1) pulses++;
      end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL spaced_done_pulses got=%0d exp=1", pulses); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL spaced_ready got=%b exp=1", ready); end
    for (int a = 0; a < 784; a += ((a == 15) ? 761 : 1)) begin
      addr = 10'(a);
      tick();
      checks++;
      if (q !== pat[a % 8]) begin
        failures++; $display("FAIL spaced_pattern addr=%0d got=%b exp=%b", a, q, pat[a % 8]);
      end
    end
  endtask

  task automatic test_pix4();
    for (int i = 0; i < 392; i++) begin
      send_byte4(8'hA5);
      if (i == 390) begin
        checks++; if (ready4 !== 1'b0) begin failures++; $display("FAIL pix4_ready_early got=%b exp=0", ready4); end
      end
      if (i == 391) begin
        checks++; if (ready4 !== 1'b1) begin failures++; $display("FAIL pix4_ready got=%b exp=1", ready4); end
        checks++; if (frame_done4 !== 1'b1) begin failures++; $display("FAIL pix4_done got=%b exp=1", frame_done4); end
      end
    end
    for (int a = 0; a < 784; a += ((a == 15) ? 765 : 1)) begin
      addr4 = 10'(a);
      tick();
      checks++;
      if (q4 !== ((a % 2 == 0) ? 4'h5 : 4'hA)) begin
        failures++; $display("FAIL pix4_value addr=%0d got=%h exp=%h", a, q4, (a % 2 == 0) ? 4'h5 : 4'hA);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    addr = 10'd0;
    for (int i = 0; i <= 50; i++) send_byte(8'hFF);
    checks++; if (q !== 1'b1) begin failures++; $display("FAIL midrst_q_before got=%b exp=1", q); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (q !== 1'b0) begin failures++; $display("FAIL midrst_q got=%b exp=0", q); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%b exp=0", ready); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", frame_done); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 98; i++) begin
      send_byte(8'hFF);
      if (i < 97) begin
        checks++; if (frame_done !== 1'b0 || ready !== 1'b0) begin
          failures++; $display("FAIL midrst_early byte=%0d done=%b ready=%b exp=0,0", i, frame_done, ready);
        end
      end else begin
        checks++; if (frame_done !== 1'b1 || ready !== 1'b1) begin
          failures++; $display("FAIL midrst_complete done=%b ready=%b exp=1,1", frame_done, ready);
        end
      end
    end
  endtask

`ifdef SNN_LOADER_PINGPONG_EN
  task automatic test_pingpong();
    for (int i = 0; i < 97; i++) begin
      send_byte(8'h00);
      checks++; if (ready !== 1'b1 || frame_done !== 1'b0) begin
        failures++; $display("FAIL pp_loading byte=%0d ready=%b done=%b exp=1,0", i, ready, frame_done);
      end
    end
    for (int a = 0; a < 784; a++) begin
      addr = 10'(a);
      tick();
      checks++; if (q !== 1'b1) begin failures++; $display("FAIL pp_old_frame addr=%0d got=%b exp=1", a, q); end
    end
    send_byte(8'h00);
    checks++; if (frame_done !== 1'b1 || ready !== 1'b1) begin
      failures++; $display("FAIL pp_swap done=%b ready=%b exp=1,1", frame_done, ready);
    end
    for (int a = 0; a < 784; a++) begin
      addr = 10'(a);
      tick();
      checks++; if (q !== 1'b0) begin failures++; $display("FAIL pp_new_frame addr=%0d got=%b exp=0", a, q); end
    end
  endtask
`else
  task automatic test_overwrite();
    addr = 10'd0;
    tick();
    send_byte(8'h00);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ow_ready got=%b exp=0", ready); end
    checks++; if (q !== 1'b1) begin failures++; $display("FAIL ow_read_before_write got=%b exp=1", q); end
    for (int a = 0; a <= 8; a++) begin
      addr = 10'(a);
      tick();
      checks++; if (q !== ((a == 8) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL ow_mixed addr=%0d got=%b exp=%b", a, q, (a == 8) ? 1'b1 : 1'b0);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_spaced_pattern();
    test_pix4();
    test_reset_mid_frame();
`ifdef SNN_LOADER_PINGPONG_EN
    test_pingpong();
`else
    test_overwrite();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snn_input_loader.md
# snn_input_loader

Parametrised image loader that sits between the UART receiver and the SNN input layer. It accepts a stream of received bytes and packs them into an image buffer. It flags when a complete frame is present and serves pixels by address to the network with one cycle of read latency. It generalises the fixed 784×1-bit loader to configurable pixel depth, frame size and byte width, supports continuous multi-frame operation, and optionally adds a ping-pong buffer.

## Interface
Parameters:
- `DATA_W`, 8: width of each incoming byte.
- `PIX_W`, 1: bits per pixel. Must divide `DATA_W`.
- `NUM_PIX`, 784: pixels per frame.
- `ADDR_W`, `$clog2(NUM_PIX)`: pixel address width.
- Derived: `NUM_BYTES` = ceil(`NUM_PIX`*`PIX_W`/`DATA_W`). This is 98 at defaults.

Ports:
- `clk`, in, 1: the single clock. Everything is on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `trigger`, in, 1: one-cycle strobe meaning `data` is valid and must be stored.
- `data`, in, `DATA_W`: received byte.
- `addr`, in, `ADDR_W`: pixel read address.
- `q`, out, `PIX_W`: registered pixel value for `addr`.
- `ready`, out, 1: a complete frame is readable.
- `frame_done`, out, 1: one-cycle pulse when the last byte of a frame is stored.

## Operation
- Packing is LSB-first. Byte k holds pixels k*(`DATA_W`/`PIX_W`) through (k+1)*(`DATA_W`/`PIX_W`)-1. Pixel p is bits [(p mod ppb)*`PIX_W` +: `PIX_W`] of byte p/ppb, where ppb = `DATA_W`/`PIX_W`. Padding bits in the final byte are stored and never read.
- Byte counter `cnt` runs 0..`NUM_BYTES`-1. Each `trigger` writes `data` to byte `cnt`, then `cnt` increments.
- State machine:
  - LOAD: entered from reset. A trigger with `cnt`=`NUM_BYTES`-1 writes the byte, sets `cnt` to 0, pulses `frame_done`, and moves to FULL.
  - FULL: `ready`=1. A trigger here starts a new frame: the byte is written to index 0, `cnt` becomes 1, and the state returns to LOAD. `ready` behaviour on this transition is set under Configuration.
- Read path: `q` <= pixel(`addr`) on every edge.
  - `addr` ≥ `NUM_PIX` gives `q`=0.
  - `q` is driven regardless of `ready`. Content is undefined when `ready`=0.
- Same-cycle write and read of the same byte is read-before-write: `q` returns the old data.
- The memory array is not reset. Only the control registers and `q` are reset.

## Timing
- Reset values: `q`=0, `ready`=0, `frame_done`=0, `cnt`=0, state LOAD. Asserting `rst_n` low mid-frame discards the partial frame immediately and asynchronously.
- Back-to-back triggers on consecutive cycles are allowed at full rate. There is no backpressure.
- A trigger on edge N for the last byte causes `frame_done`=1 and `ready`=1 after edge N. The byte is readable via `addr` on edge N+1, with `q` valid after edge N+1.
- Read latency is one cycle: `addr` sampled at edge N appears on `q` after edge N.
- `frame_done` is exactly one cycle wide. It never asserts on a partial frame.

## Configuration
- `SNN_LOADER_PINGPONG_EN` defined: two banks, each `NUM_BYTES`×`DATA_W`.
  - Writes target the write bank; reads target the read bank.
  - On `frame_done` the banks swap in the same edge as the pulse.
  - Once the first frame completes, `ready` stays 1 permanently, including while a new frame loads.
  - `q` always reflects the last complete frame.
  - Reset sets write bank = 0 and read bank = 1.
- Not defined: single bank.
  - A trigger in FULL clears `ready` on the same edge.
  - The buffer is overwritten in place, so reads during loading see a mix of old and new data.

## Test plan
- Defaults, reset, 98 triggers of 8'hFF, one per cycle:
  - `ready`=0 through byte 96.
  - `frame_done` and `ready` rise after byte 97.
  - Sweeping `addr` 0..783 gives `q`=1 at each address with 1-cycle latency.
  - `addr`=900 gives `q`=0.
- Defaults, 98 bytes of 8'b10010011, triggers spaced 50 cycles apart:
  - `q` for `addr` 0..7 is 1,1,0,0,1,0,0,1, repeating every 8 addresses.
  - `frame_done` pulses exactly once.
- `PIX_W`=4, `NUM_PIX`=784 (392 bytes), bytes 8'hA5:
  - even addresses give `q`=4'h5, odd addresses give 4'hA.
  - `ready` rises after byte 391.
- Reset asserted after byte 50 of 98:
  - `ready`, `q` and `frame_done` go to 0 at once.
  - A following full 98-byte frame completes normally at byte 97, not earlier.
- Without the macro: load 8'hFF, then send one 8'h00 byte. `ready` falls on that edge, `addr` 0..7 gives `q`=0 and `addr` 8 gives `q`=1.
- With the macro: load 8'hFF, then 97 bytes of 8'h00.
  - `ready` stays 1 and `q`=1 at all addresses.
  - After the 98th 8'h00 byte, `frame_done` pulses and `q`=0 at all addresses.
